frame_loader: RTL and testbench
===============================

Name: frame_loader

Overview:
- Input stage of the Viterbi decoder datapath; sits directly upstream of the symbol slicer.
- Accepts 16-bit received-data words from the PS side over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents one frame at a time on o_data_frame, holding it stable while it pulses o_en_s once per slice.
- Marks frame and block boundaries (o_sof, o_eob) so the branch-metric and traceback stages can align.

Parameters:
- FRAME_W, 16, data-frame width in bits; must equal the slicer input width.
- FIFO_DEPTH, 2, frame buffer entries (ping-pong); power of two, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- i_code_rate  input  1  `CODE_RATE_2 or `CODE_RATE_3, from param_def
- i_valid  input  1  upstream word valid
- o_ready  output  1  loader can accept a word
- i_data  input  FRAME_W  received frame word, MSB first
- i_last  input  1  word is the final frame of a code block
- o_data_frame  output  FRAME_W  frame presented to the slicer
- o_en_s  output  1  slice enable, one slice consumed per high cycle
- o_sof  output  1  first en_s cycle of a frame
- o_eob  output  1  final en_s cycle of a frame tagged last
- o_busy  output  1  FSM in ISSUE, or FIFO not empty

Behaviour:
- Reset (rst=0, async): FIFO emptied and all outputs 0, including o_data_frame. FSM goes to IDLE. A reset mid-frame discards the frame in flight and all buffered frames, with no partial eob.
- Push: on a clk edge with i_valid && o_ready, {i_data, i_last} is written.
- o_ready = !full, registered from the FIFO count with no combinational path from pop.
- SLICES, latched per frame at pop: 4 for `CODE_RATE_2 (4 bits/slice × 4 = 16); 2 for `CODE_RATE_3 (6 bits/slice × 2 = 12).
- Rate-3 frames carry valid data in [15:4]; bits [3:0] are don't-care and are passed unchanged.
- i_code_rate changes take effect only at the next pop.
- FSM states:
  - IDLE: o_en_s=0. If the FIFO is not empty, pop, load o_data_frame, load slice_cnt=SLICES-1, and go to ISSUE.
  - ISSUE: o_en_s=1 and slice_cnt decrements each cycle. o_sof=1 when slice_cnt==SLICES-1. o_eob=1 when slice_cnt==0 and the frame's last flag is set.
  - At slice_cnt==0 with the FIFO not empty: pop the next frame on the same edge and stay in ISSUE. There is no bubble, so o_en_s stays high across frames.
  - At slice_cnt==0 with the FIFO empty: go to IDLE.
- Latency: a word accepted at edge t into an empty loader in IDLE is popped at edge t+1. o_en_s and o_data_frame are valid from edge t+1 for SLICES cycles.
- o_data_frame holds its value in IDLE and changes only on pop.
- Simultaneous push and pop: count unchanged; the pop reads the older entry. Push when full is impossible because o_ready=0.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Rate 3 tagged last: eob lands on the 2nd en_s cycle. A 1-slice frame is not possible.
- Sustained throughput: one word per 4 cycles at rate 2, one per 2 cycles at rate 3. With FIFO_DEPTH=2, upstream sees o_ready=0 for at most SLICES-1 consecutive cycles while the FIFO is full.

Decomposition:
- param_def additions: FRAME_W, SLICES_RATE2=4, SLICES_RATE3=2, and the loader state enum (IDLE, ISSUE) as a typedef. CODE_RATE_2/CODE_RATE_3 are reused unchanged.
- Sub-module frame_fifo: synchronous FIFO of {last, data}, FIFO_DEPTH entries, push/pop/full/empty/count, same clk/rst.
- frame_loader holds the FSM, slice counter and output registers.

Test Plan:
- Reset values: hold rst=0 for 3 cycles, then release with i_valid=0 → o_ready=1; o_en_s, o_sof, o_eob and o_busy=0; o_data_frame=16'h0000.
- Single rate-2 frame: push 16'hA5C3, last=1, at edge t → o_en_s=1 at edges t+1..t+4 with o_data_frame=16'hA5C3 throughout; o_sof at t+1; o_eob at t+4; o_en_s=0 at t+5.
- Back-to-back rate 2: push 16'h1234, 16'h5678, 16'h9ABC with i_valid held high → 12 contiguous en_s cycles; o_data_frame steps at cycles 1, 5 and 9; o_ready=0 while the FIFO holds 2 entries; o_sof pulses exactly three times.
- Rate 3: i_code_rate=`CODE_RATE_3, push 16'hFFF0 then 16'h0AB0 with last=1 on the second → 4 contiguous en_s cycles, 2 per frame; o_eob only on the 4th cycle.
- Rate switch: push frame A at rate 2, then set i_code_rate=`CODE_RATE_3 during A's 2nd en_s cycle and push frame B → A gets 4 slices, B gets 2.
- Reset mid-operation: assert rst during the 2nd slice of the first of two buffered frames → outputs 0 immediately (async); after release, no en_s appears and o_busy=0.

Source files
------------

// File: rtl/frame_loader_pkg.sv
// Shared constants and types for the Viterbi input-stage frame loader.
package frame_loader_pkg;

    localparam int unsigned FRAME_W      = 16;
    localparam int unsigned SLICES_RATE2 = 4;
    localparam int unsigned SLICES_RATE3 = 2;

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } loader_state_e;

    // Initial slice counter value for a frame popped at the given rate.
    function automatic logic [1:0] slice_max(input logic code_rate);
        return (code_rate == CODE_RATE_3) ? 2'(SLICES_RATE3 - 1) : 2'(SLICES_RATE2 - 1);
    endfunction

endpackage

// File: rtl/frame_loader_fifo.sv
// Small synchronous FIFO holding {last, data} frame words for the loader.
module frame_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             not_full_q, not_full_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_wdata;
            wr_ptr_d        = wr_ptr_q + PtrOne;
        end
        if (i_pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        not_full_d = (count_d != CntFull);
    end

    // Full flag is registered so upstream ready has no path from the pop decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_full  = !not_full_q;
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/frame_loader.sv
// Viterbi input stage: buffers received words and issues each frame to the
// slicer as a burst of slice enables with start-of-frame / end-of-block marks.
module frame_loader #(
    parameter int unsigned FRAME_W    = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_code_rate,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [FRAME_W-1:0] i_data,
    input  logic               i_last,
    output logic [FRAME_W-1:0] o_data_frame,
    output logic               o_en_s,
    output logic               o_sof,
    output logic               o_eob,
    output logic               o_busy
);

    import frame_loader_pkg::*;

    loader_state_e             state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [1:0]                max_q, max_d;
    logic [FRAME_W-1:0]        data_q, data_d;
    logic                      last_q, last_d;

    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FRAME_W:0]          fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign fifo_push = i_valid && o_ready;

    frame_fifo #(
        .WIDTH (FRAME_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (fifo_push),
        .i_wdata ({i_last, i_data}),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        data_d   = data_q;
        last_d   = last_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (cnt_q == 2'd0) begin
                    // Chain straight into the next frame so en_s has no bubble.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (fifo_pop) begin
            data_d = fifo_rdata[FRAME_W-1:0];
            last_d = fifo_rdata[FRAME_W];
            max_d  = slice_max(i_code_rate);
            cnt_d  = slice_max(i_code_rate);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            max_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign o_ready      = !fifo_full;
    assign o_data_frame = data_q;
    assign o_en_s       = (state_q == StIssue);
    assign o_sof        = o_en_s && (cnt_q == max_q);
    assign o_eob        = o_en_s && (cnt_q == 2'd0) && last_q;
    assign o_busy       = o_en_s || (fifo_count != '0);

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: directed scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_frame_loader;
    import frame_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_code_rate;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_data;
    logic        i_last;
    logic [15:0] o_data_frame;
    logic        o_en_s, o_sof, o_eob, o_busy;

    int checks = 0;
    int failures = 0;

    frame_loader #(
        .FRAME_W    (16),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_code_rate  (i_code_rate),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_data_frame (o_data_frame),
        .o_en_s       (o_en_s),
        .o_sof        (o_sof),
        .o_eob        (o_eob),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Behavioural model: a 2-deep queue of words and the frame currently being
    // issued with the number of slices it still has to emit.
    logic [16:0] mq[$];
    logic [15:0] m_data;
    logic        m_last;
    int          m_rem;
    int          m_slices;
    bit          m_active;
    bit          m_ready;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_data = '0; m_last = 1'b0; m_rem = 0; m_slices = 0;
            m_active = 1'b0; m_ready = 1'b0;
        end else begin
            bit push, pop;
            push = i_valid && m_ready;
            pop  = (!m_active || m_rem == 1) && (mq.size() > 0);
            if (pop) begin
                {m_last, m_data} = mq.pop_front();
                m_slices = (i_code_rate == CODE_RATE_3) ? 2 : 4;
                m_rem    = m_slices;
                m_active = 1'b1;
            end else if (m_active) begin
                if (m_rem == 1) m_active = 1'b0;
                else m_rem--;
            end
            if (push) mq.push_back({i_last, i_data});
            m_ready = (mq.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_en_s",  o_en_s, m_active);
            chk("m_data",  o_data_frame, m_data);
            chk("m_sof",   o_sof, m_active && (m_rem == m_slices));
            chk("m_eob",   o_eob, m_active && (m_rem == 1) && m_last);
            chk("m_ready", o_ready, m_ready);
            chk("m_busy",  o_busy, m_active || (mq.size() > 0));
        end
    end

    // Burst statistics for the directed scenarios.
    int          en_cnt, sof_cnt, eob_cnt, run, max_run, eob_pos;
    bit          saw_nready;
    logic [15:0] data_log [16];

    task automatic clear_stats();
        en_cnt = 0; sof_cnt = 0; eob_cnt = 0; run = 0; max_run = 0; eob_pos = 0;
        saw_nready = 0;
        for (int i = 0; i < 16; i++) data_log[i] = 'x;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!o_ready) saw_nready = 1;
            if (o_en_s) begin
                en_cnt++;
                run++;
                if (run > max_run) max_run = run;
                if (run < 16) data_log[run] = o_data_frame;
                if (o_sof) sof_cnt++;
                if (o_eob) begin eob_cnt++; eob_pos = run; end
            end else begin
                run = 0;
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic push_word(input logic [15:0] d, input logic l);
        bit acc = 0;
        i_valid = 1'b1; i_data = d; i_last = l;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = o_ready;
            @(negedge clk);
        end
        chk("push_accept", acc, 1'b1);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((o_busy || o_en_s) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", o_busy | o_en_s, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_code_rate = CODE_RATE_2;
        clear_stats();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_en_s",  o_en_s, 1'b0);
        chk("rst_sof",   o_sof, 1'b0);
        chk("rst_eob",   o_eob, 1'b0);
        chk("rst_busy",  o_busy, 1'b0);
        chk("rst_data",  o_data_frame, 16'h0000);

        // Single rate-2 frame, tagged last.
        push_word(16'hA5C3, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("single_en", o_en_s, (k <= 4));
            if (k <= 4) begin
                chk("single_data", o_data_frame, 16'hA5C3);
                chk("single_sof", o_sof, (k == 1));
                chk("single_eob", o_eob, (k == 4));
            end
        end
        wait_idle();

        // Back-to-back rate 2.
        clear_stats();
        push_word(16'h1234, 1'b0);
        push_word(16'h5678, 1'b0);
        push_word(16'h9ABC, 1'b1);
        wait_idle();
        chk("b2b_en_cnt", en_cnt, 12);
        chk("b2b_run", max_run, 12);
        chk("b2b_sof", sof_cnt, 3);
        chk("b2b_eob", eob_cnt, 1);
        chk("b2b_nready", saw_nready, 1'b1);
        chk("b2b_d1", data_log[1], 16'h1234);
        chk("b2b_d4", data_log[4], 16'h1234);
        chk("b2b_d5", data_log[5], 16'h5678);
        chk("b2b_d9", data_log[9], 16'h9ABC);

        // Rate 3: two slices per frame, eob on the last slice of the tagged frame.
        clear_stats();
        i_code_rate = CODE_RATE_3;
        push_word(16'hFFF0, 1'b0);
        push_word(16'h0AB0, 1'b1);
        wait_idle();
        chk("r3_en_cnt", en_cnt, 4);
        chk("r3_run", max_run, 4);
        chk("r3_eob_cnt", eob_cnt, 1);
        chk("r3_eob_pos", eob_pos, 4);
        chk("r3_d1", data_log[1], 16'hFFF0);
        chk("r3_d3", data_log[3], 16'h0AB0);

        // Rate switch during frame A's second slice.
        clear_stats();
        i_code_rate = CODE_RATE_2;
        push_word(16'hC0DE, 1'b0);
        @(negedge clk);
        @(negedge clk);
        i_code_rate = CODE_RATE_3;
        push_word(16'hBEE0, 1'b1);
        wait_idle();
        chk("sw_en_cnt", en_cnt, 6);
        chk("sw_run", max_run, 6);
        chk("sw_sof", sof_cnt, 2);
        chk("sw_d4", data_log[4], 16'hC0DE);
        chk("sw_d5", data_log[5], 16'hBEE0);
        chk("sw_eob_pos", eob_pos, 6);

        // Asynchronous reset during the second slice of the first of two frames.
        i_code_rate = CODE_RATE_2;
        push_word(16'h1111, 1'b0);
        push_word(16'h2222, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_en_s", o_en_s, 1'b0);
        chk("mid_sof", o_sof, 1'b0);
        chk("mid_eob", o_eob, 1'b0);
        chk("mid_busy", o_busy, 1'b0);
        chk("mid_ready", o_ready, 1'b0);
        chk("mid_data", o_data_frame, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        clear_stats();
        repeat (10) @(negedge clk);
        chk("post_rst_en", en_cnt, 0);
        chk("post_rst_busy", o_busy, 1'b0);

        // Randomized traffic with rate changes and one asynchronous reset.
        for (int c = 0; c < 1500; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = 16'($urandom);
            i_last  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) i_code_rate = ~i_code_rate;
            if (c == 700) begin
                #3 rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        i_valid = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
